fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the decoder: owns the PC, issues word requests to instruction memory,
//  buffers returned words in a small queue, and presents {inst, pc} to decode with a valid/ready handshake.
//  Accepts redirects (branch/jal/jalr/trap) from execute and discards stale in-flight responses.
// PARAMETERS
//  RESET_PC         32'h0000_0000  PC value loaded on reset
//  QUEUE_DEPTH      4              instruction queue entries; power of two, >=2
//  MAX_OUTSTANDING  2              maximum imem requests in flight, 1..QUEUE_DEPTH
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   reset, asynchronous, active-high
//  imem_req_valid    out  1   request valid
//  imem_req_ready    in   1   memory accepts request this cycle
//  imem_req_addr     out  32  word-aligned fetch address
//  imem_resp_valid   in   1   response valid; responses return in request order, always accepted
//  imem_resp_data    in   32  instruction word
//  inst_valid        out  1   queue head valid toward decode
//  inst_ready        in   1   decode consumes head
//  inst              out  32  instruction word at head
//  inst_pc           out  32  PC of head instruction
//  redirect_valid    in   1   redirect fetch to redirect_pc
//  redirect_pc       in   32  new PC
//  fetch_misalign    out  1   (FETCH_MISALIGN_TRAP_EN only) sticky misaligned-target flag
// BEHAVIOUR
//  Reset: pc=RESET_PC, queue empty, outstanding=0, discard=0; imem_req_valid=0, inst_valid=0,
//   inst=0, inst_pc=0, fetch_misalign=0. Requests may start the first cycle after rst deasserts.
//  Issue: imem_req_valid = !redirect_valid && (occupancy + outstanding < QUEUE_DEPTH)
//   && (outstanding < MAX_OUTSTANDING). imem_req_addr = pc. On req fire: pc += 4, outstanding++.
//   Once asserted, imem_req_valid/addr hold until fire unless a redirect arrives.
//  Request PCs are tracked in a MAX_OUTSTANDING-deep PC FIFO. On response: pop pc; if discard>0 then
//   discard--, word dropped; else enqueue {data, pc}. Outstanding is decremented on every response.
//   The issue rule guarantees space.
//  Output: inst_valid = queue non-empty && !redirect_valid; head pops when inst_valid && inst_ready.
//   Pop and enqueue in the same cycle keep occupancy unchanged. Full queue blocks new issue only.
//   Queue pointers wrap modulo QUEUE_DEPTH. inst/inst_pc show the head entry and hold their value when empty.
//  Redirect (edge in which redirect_valid=1): queue flushed, pc=redirect_pc & ~3.
//   Discard = outstanding - resp_fire_this_cycle + req_fire_this_cycle. No request fires in a redirect cycle,
//   so the last term is 0. A response in the redirect cycle is dropped.
//   Back-to-back redirects accumulate discard correctly; the last redirect wins.
//  Latency: with zero-latency memory (resp the cycle after req), the first inst_valid is 2 cycles after
//   reset release or redirect. Sustained throughput is 1 inst/cycle when MAX_OUTSTANDING>=2.
//  rst asserted mid-operation: all state returns to reset values immediately. In-flight memory responses
//   after reset are not tracked; the memory shares rst.
//  Arithmetic: pc wraps at 2^32 (0xFFFF_FFFC + 4 = 0). Counters are sized $clog2(N)+1.
// CONFIGURATION
//  `FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 sets sticky fetch_misalign.
//   Fetch is suppressed (imem_req_valid=0) until the next aligned redirect, which clears the flag.
//  Not defined: port absent; low bits are silently cleared and fetch continues at redirect_pc & ~3.
// STRUCTURE
//  define.v gains `RESET_PC_DEFAULT and `INST_NOP (32'h0000_0013, addi x0,x0,0), used by downstream flush.
//  Sub-module fetch_queue: synchronous FIFO of {pc[31:0], inst[31:0]} with push/pop/flush, count, full/empty.
//   It is instantiated once for the instruction queue. The PC FIFO for in-flight requests is the same
//   module, instantiated with DEPTH=MAX_OUTSTANDING.
// TESTING
//  1 Reset release, memory returning resp 1 cycle after every req -> addresses 0,4,8,.. and
//    inst_pc 0,4,8,.. on consecutive cycles; steady-state inst_valid=1.
//  2 inst_ready held 0 -> exactly QUEUE_DEPTH entries queued, imem_req_valid drops.
//    Release inst_ready -> words drained in order with no loss or duplicate.
//  3 Redirect to 0x100 with 2 requests outstanding -> both responses dropped; next inst_pc=0x100.
//    inst_valid=0 in the redirect cycle.
//  4 Redirect in the same cycle as a response and a decode pop -> response dropped, queue empty,
//    discard = outstanding-1.
//  5 imem_req_ready held low 5 cycles -> req_valid/addr stable; fetch resumes at the same addr.
//  6 FETCH_MISALIGN_TRAP_EN: redirect 0x102 -> fetch_misalign=1, no requests.
//    Redirect 0x200 -> flag clears, fetch restarts at 0x200. Without the macro: fetch at 0x100.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//  Shared definitions for the instruction fetch slice.
//  RESET_PC_DEFAULT : default PC loaded on reset
//  INST_NOP         : canonical no-op (addi x0,x0,0) for downstream flush logic
//  PC_STEP          : byte distance between consecutive instruction words
//  fetch_entry_t    : one queued instruction, {pc, inst}
//  align_pc()       : clears the two low address bits of a jump target

package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
//  Synchronous FIFO with push/pop/flush and occupancy count. Used both as the
//  instruction queue ({pc, inst}) and as the in-flight request PC tracker.
//  DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
// Parameters
//  DEPTH      number of entries (>=1)
//  WIDTH      entry width in bits
// Ports
//  clk        rising-edge clock
//  rst        asynchronous active-high reset
//  push       write push_data (accepted if not full, or full with a pop)
//  push_data  entry to write
//  pop        remove head entry (ignored when empty)
//  flush      discard all entries; takes priority over push/pop
//  head_data  oldest entry (undefined content when empty)
//  count      number of valid entries
//  full       count == DEPTH
//  empty      count == 0

module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full queue can still take a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush simply rewinds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; contents are only observed while count > 0.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//  Instruction fetch stage. Owns the PC, issues word requests to instruction
//  memory, tracks the PC of every in-flight request, buffers returned words in
//  a small queue and hands {inst, pc} to decode over a valid/ready handshake.
//  Redirects flush the queue and mark all in-flight responses for discard.
// Configuration macro
//  FETCH_MISALIGN_TRAP_EN : when defined, a redirect to a non word-aligned
//   target raises sticky fetch_misalign and halts fetch until an aligned
//   redirect arrives. When undefined the port is absent and the low target
//   bits are silently cleared.
// Parameters
//  RESET_PC          PC loaded on reset
//  QUEUE_DEPTH       instruction queue entries (power of two, >=2)
//  MAX_OUTSTANDING   imem requests allowed in flight (1..QUEUE_DEPTH)
// Ports
//  clk, rst                      clock, asynchronous active-high reset
//  imem_req_valid/ready/addr     request channel to instruction memory
//  imem_resp_valid/data          in-order response channel, always accepted
//  inst_valid/ready, inst, inst_pc   decode handshake and head entry
//  redirect_valid, redirect_pc   redirect from execute (branch/jump/trap)
//  fetch_misalign                sticky misaligned-target flag (macro only)

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int QCNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int OCNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [31:0]       pc_q;
    logic [OCNT_W-1:0] discard_q;
    logic [OCNT_W-1:0] outstanding;
    logic              pend_full;
    logic              pend_empty;
    logic [31:0]       pend_pc;
    logic [QCNT_W-1:0] occupancy;
    logic              q_full;
    logic              q_empty;
    fetch_entry_t      q_head;
    fetch_entry_t      q_push_entry;
    fetch_entry_t      hold_q;
    fetch_entry_t      shown;
    logic              has_room;
    logic              fetch_blocked;
    logic              req_fire;
    logic              resp_accept;
    logic              resp_drop;
    logic              q_push;
    logic              q_pop;
    logic              unused_q_full;

    assign unused_q_full = q_full;

    // Issue gating. Counting in-flight requests against queue space means a
    // response can never find the queue full. Once raised, the request can only
    // be withdrawn by a redirect: occupancy and outstanding never grow without
    // a fire.
    assign has_room       = (int'(occupancy) + int'(outstanding)) < QUEUE_DEPTH;
    assign imem_req_valid = !rst && !redirect_valid && !fetch_blocked
                            && has_room && !pend_full;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing tracked (e.g. stale ones straddling a reset) are ignored.
    assign resp_accept  = imem_resp_valid && !pend_empty;
    assign resp_drop    = redirect_valid || (discard_q != '0);
    assign q_push       = resp_accept && !resp_drop;
    assign q_push_entry = '{pc: pend_pc, inst: imem_resp_data};

    assign inst_valid = !q_empty && !redirect_valid;
    assign q_pop      = inst_valid && inst_ready;

    // PC tracker for in-flight requests; its count is the outstanding counter.
    fetch_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (32)
    ) u_pend_pcs (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (resp_accept),
        .flush     (1'b0),
        .head_data (pend_pc),
        .count     (outstanding),
        .full      (pend_full),
        .empty     (pend_empty)
    );

    // Instruction queue toward decode; a redirect throws away everything buffered.
    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_push_entry),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head_data (q_head),
        .count     (occupancy),
        .full      (q_full),
        .empty     (q_empty)
    );

    // PC advances on each accepted request; a redirect overrides it and never
    // coincides with a fire because issue is blocked in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= align_pc(redirect_pc);
        end else if (req_fire) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    // Discard counter: on a redirect every request still in flight after this
    // cycle's response becomes stale. Back-to-back redirects recompute from the
    // live outstanding count, so nothing is double counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            discard_q <= '0;
        end else if (redirect_valid) begin
            discard_q <= outstanding - OCNT_W'(resp_accept);
        end else if (resp_accept && (discard_q != '0)) begin
            discard_q <= discard_q - OCNT_W'(1);
        end
    end

    // Keep the last presented head so inst/inst_pc hold steady while the queue is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (!q_empty) begin
            hold_q <= q_head;
        end
    end

    assign shown   = q_empty ? hold_q : q_head;
    assign inst    = shown.inst;
    assign inst_pc = shown.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    // Every redirect re-evaluates the flag: a misaligned target sets it, an
    // aligned one clears it and lets fetch resume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            misalign_q <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign fetch_misalign = misalign_q;
    assign fetch_blocked  = misalign_q;
`else
    assign fetch_blocked = 1'b0;
`endif

endmodule
